// File: rtl/secuenciador_vector.sv
// Vector element sequencer: accepts one instruction, issues its elements one per cycle with an index, drains, pulses done.
// Latency: first element one cycle after acceptance; done L+DRAIN+1 cycles after acceptance (plus memory stalls).
// Backpressure: instr_ready only in IDLE; memory-class elements issue only when mem_ready is high.
module secuenciador_vector #(
   parameter int VL_W  = 3,
   parameter int DRAIN = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            instr_valid,
   output logic            instr_ready,
   input  logic [3:0]      opcode_in,
   input  logic [VL_W:0]   vl_in,
   input  logic            mem_ready,
   input  logic            flush,
   output logic            elem_valid,
   output logic [VL_W-1:0] elem_idx,
   output logic [3:0]      opcode_out,
   output logic            last_elem,
   output logic            busy,
   output logic            done
);

   localparam int CW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

   typedef logic [VL_W:0] len_t;
   typedef logic [CW-1:0] cnt_t;

   localparam len_t MAX_LEN = len_t'(1 << VL_W);
   localparam cnt_t CNT_END = cnt_t'(DRAIN - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t     state_q, state_d;
   len_t       idx_q, idx_d;
   len_t       len_q, len_d;
   logic [3:0] opc_q, opc_d;
   cnt_t       cnt_q, cnt_d;
   logic       done_q, done_d;

   logic       is_scalar_in;
   logic       is_mem;
   len_t       eff_len;
   logic       issue_ok;
   logic       last_hit;

   // Classify the offered and the latched opcode; clamp the offered length
   always_comb begin
      is_scalar_in = (opcode_in == 4'b1100) || (opcode_in == 4'b1101);
      is_mem       = opc_q inside {4'b0011, 4'b0100, 4'b1110, 4'b1111};
      if (is_scalar_in) begin
         eff_len = len_t'(1);
      end else if (vl_in > MAX_LEN) begin
         eff_len = MAX_LEN;
      end else begin
         eff_len = vl_in;
      end
   end

   // An element issues in ISSUE unless flushed or a memory op is stalled
   always_comb begin
      issue_ok = (state_q == ST_ISSUE) && !flush && (!is_mem || mem_ready);
      last_hit = (idx_q == (len_q - len_t'(1)));
   end

   assign instr_ready = (state_q == ST_IDLE);
   assign busy        = (state_q != ST_IDLE);
   assign elem_valid  = issue_ok;
   assign last_elem   = issue_ok && last_hit;
   assign elem_idx    = idx_q[VL_W-1:0];
   assign opcode_out  = opc_q;
   assign done        = done_q;

   // Next-state logic: accept, issue elements, count the drain, flush abort
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      len_d   = len_q;
      opc_d   = opc_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      if (flush) begin
         state_d = ST_IDLE;
         idx_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (instr_valid) begin
                  opc_d   = opcode_in;
                  len_d   = eff_len;
                  idx_d   = '0;
                  cnt_d   = '0;
                  state_d = (eff_len == '0) ? ST_DRAIN : ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (issue_ok) begin
                  if (last_hit) begin
                     state_d = ST_DRAIN;
                     cnt_d   = '0;
                  end else begin
                     idx_d = idx_q + len_t'(1);
                  end
               end
            end
            ST_DRAIN: begin
               if (cnt_q == CNT_END) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + cnt_t'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         len_q   <= '0;
         opc_q   <= 4'b0000;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         opc_q   <= opc_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_secuenciador_vector.sv
// Directed bench for secuenciador_vector with hand-computed element masks and done latencies.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Latency numbers count the acceptance edge as cycle 0.
module tb_secuenciador_vector;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       instr_valid = 1'b0;
   logic [3:0] opcode_in = 4'd0;
   logic [3:0] vl_in = 4'd0;
   logic       mem_ready = 1'b1;
   logic       flush = 1'b0;
   logic       instr_ready, elem_valid, last_elem, busy, done;
   logic [2:0] elem_idx;
   logic [3:0] opcode_out;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   secuenciador_vector #(.VL_W(3), .DRAIN(3)) dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .opcode_in(opcode_in), .vl_in(vl_in), .mem_ready(mem_ready), .flush(flush),
      .elem_valid(elem_valid), .elem_idx(elem_idx), .opcode_out(opcode_out),
      .last_elem(last_elem), .busy(busy), .done(done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Offer one instruction from IDLE; returns 1ns after the acceptance edge
   task automatic accept(input logic [3:0] op, input logic [3:0] vl);
      @(posedge clk); #1;
      opcode_in = op; vl_in = vl; instr_valid = 1'b1;
      @(negedge clk);
      check("instr_ready before accept", instr_ready, 1);
      @(posedge clk); #1;
      instr_valid = 1'b0;
   endtask

   // Run one instruction up to its done cycle; returns at the falling edge of that cycle
   task automatic run_instr(input string tag, input logic [3:0] op, input logic [3:0] vl,
                            input logic [31:0] mem_pat, input logic [31:0] vmask,
                            input int exp_n, input int exp_lat,
                            input bit b2b, input logic [3:0] nop, input logic [3:0] nvl);
      int cnt;
      int lat;
      cnt = 0;
      lat = 0;
      accept(op, vl);
      if (b2b) begin
         opcode_in = nop; vl_in = nvl; instr_valid = 1'b1;
      end
      for (int k = 1; k <= 32; k++) begin
         mem_ready = mem_pat[k-1];
         @(negedge clk);
         check({tag, " elem_valid"}, elem_valid, vmask[k-1]);
         if (elem_valid) begin
            check({tag, " elem_idx"}, elem_idx, cnt);
            check({tag, " last_elem"}, last_elem, (cnt == exp_n - 1));
            cnt++;
         end else if (busy && cnt < exp_n) begin
            check({tag, " idx hold"}, elem_idx, cnt);
         end
         if (done) begin
            lat = k;
            break;
         end
         @(posedge clk); #1;
      end
      mem_ready = 1'b1;
      check({tag, " element count"}, cnt, exp_n);
      check({tag, " done latency"}, lat, exp_lat);
      check({tag, " busy at done"}, busy, 0);
      check({tag, " opcode_out"}, opcode_out, op);
   endtask

   initial begin
      int  n;
      logic seen;

      // Reset state
      #12;
      check("reset busy", busy, 0);
      check("reset elem_valid", elem_valid, 0);
      check("reset done", done, 0);
      check("reset instr_ready", instr_ready, 1);
      check("reset elem_idx", elem_idx, 0);
      check("reset opcode_out", opcode_out, 0);
      rst_n = 1'b1;

      // 1: vector op, full length: 8 elements, done 12 cycles after acceptance
      run_instr("t1", 4'h0, 4'd8, 32'hFFFF_FFFF, 32'h0000_00FF, 8, 12, 1'b0, 4'h0, 4'h0);
      @(posedge clk); #1;
      @(negedge clk);
      check("t1 done single cycle", done, 0);

      // 2: memory op with stalls 1,0,0,1,1,0,1: done 11 cycles after acceptance
      run_instr("t2", 4'h3, 4'd4, 32'hFFFF_FF80 | 32'h59, 32'h0000_0059, 4, 11, 1'b0, 4'h0, 4'h0);

      // 3: scalar op issues once; over-length vector op is clamped to 8
      run_instr("t3s", 4'hD, 4'd6, 32'hFFFF_FFFF, 32'h0000_0001, 1, 5, 1'b0, 4'h0, 4'h0);
      run_instr("t3c", 4'h1, 4'd15, 32'hFFFF_FFFF, 32'h0000_00FF, 8, 12, 1'b0, 4'h0, 4'h0);

      // 4: zero length, then a second instruction held valid and accepted in the done cycle
      run_instr("t4", 4'h2, 4'd0, 32'hFFFF_FFFF, 32'h0, 0, 4, 1'b1, 4'h8, 4'd3);
      check("t4 ready in done cycle", instr_ready, 1);
      @(posedge clk); #1;
      instr_valid = 1'b0;
      @(negedge clk);
      check("t4 b2b elem_valid", elem_valid, 1);
      check("t4 b2b elem_idx", elem_idx, 0);
      check("t4 b2b opcode_out", opcode_out, 8);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         n++;
         @(negedge clk);
         if (done) break;
      end
      check("t4 b2b cycles to done", n, 6);

      // 5: flush while element 2 is issuing
      accept(4'h0, 4'd8);
      @(negedge clk);
      check("t5 idx0", elem_idx, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("t5 idx1", elem_idx, 1);
      @(posedge clk); #1;
      flush = 1'b1;
      @(negedge clk);
      check("t5 elem_valid in flush cycle", elem_valid, 0);
      check("t5 elem_idx in flush cycle", elem_idx, 2);
      check("t5 busy in flush cycle", busy, 1);
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      check("t5 busy after flush", busy, 0);
      check("t5 instr_ready after flush", instr_ready, 1);
      seen = done;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         seen = seen | done;
      end
      check("t5 no done after flush", seen, 0);
      // flush beats acceptance in IDLE
      @(posedge clk); #1;
      instr_valid = 1'b1; flush = 1'b1; opcode_in = 4'h9; vl_in = 4'd2;
      @(posedge clk); #1;
      instr_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      check("t5 flush blocks accept busy", busy, 0);
      check("t5 flush blocks accept opcode", opcode_out, 0);
      run_instr("t5b", 4'h5, 4'd3, 32'hFFFF_FFFF, 32'h0000_0007, 3, 7, 1'b0, 4'h0, 4'h0);

      // 6: asynchronous reset in the middle of DRAIN
      accept(4'h7, 4'd1);
      @(negedge clk);
      check("t6 single element last", last_elem, 1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      check("t6 busy mid-drain", busy, 1);
      check("t6 opcode mid-drain", opcode_out, 7);
      #2 rst_n = 1'b0;
      #1;
      check("t6 rst busy", busy, 0);
      check("t6 rst done", done, 0);
      check("t6 rst elem_valid", elem_valid, 0);
      check("t6 rst last_elem", last_elem, 0);
      check("t6 rst elem_idx", elem_idx, 0);
      check("t6 rst opcode_out", opcode_out, 0);
      check("t6 rst instr_ready", instr_ready, 1);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         seen = seen | done;
      end
      check("t6 no done after reset", seen, 0);
      run_instr("t6b", 4'h6, 4'd2, 32'hFFFF_FFFF, 32'h0000_0003, 2, 6, 1'b0, 4'h0, 4'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
